// File: rtl/z_track_decoder_pkg.sv
// Drum track word geometry, Z2 sync signature and the expected-Z2 pattern shared by decoder and generator.
// Pure definitions: no latency, no flow control.
package z_track_decoder_pkg;

  localparam int WORD_BITS = 40;
  localparam int ADR_BITS  = 7;
  localparam int ADR_START = 32;
  localparam int LOCK_MISS = 2;
  localparam int BITN_W    = 6;
  localparam int MISS_W    = 2;
  localparam int SIG_BITS  = 10;

  localparam logic [BITN_W-1:0]   LAST_BIT  = BITN_W'(WORD_BITS - 1);
  localparam logic [BITN_W-1:0]   ADR_FIRST = BITN_W'(ADR_START);
  localparam logic [BITN_W-1:0]   ADR_LAST  = BITN_W'(ADR_START + ADR_BITS - 1);
  localparam logic [MISS_W-1:0]   MISS_LAST = MISS_W'(LOCK_MISS - 1);
  // Z2 over n=30..39, oldest bit in the MSB
  localparam logic [SIG_BITS-1:0] SYNC_SIG  = 10'b0111000011;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } sync_state_e;

  function automatic logic z2_expect(input logic [BITN_W-1:0] n);
    return (n == 6'd31) || (n == 6'd32) || (n == 6'd33) ||
           (n == 6'd38) || (n == 6'd39);
  endfunction

endpackage

// File: rtl/z2_sync_detector.sv
// Z2 framing: hunts for the sync signature, then tracks bit index and drops lock after repeated misses.
// Latency: LOCK rises on the edge sampling n=39; no backpressure (free-running track).
module z2_sync_detector
  import z_track_decoder_pkg::*;
(
  input  logic              Z1,
  input  logic              CLR,
  input  logic              Z2,
  output logic              lock,
  output logic [BITN_W-1:0] bitn,
  output logic              sync_err,
  output logic              drop
);

  sync_state_e         state_q, state_d;
  logic [SIG_BITS-1:0] hist_q, hist_d;
  logic [BITN_W-1:0]   bitn_q, bitn_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic                sync_err_q, sync_err_d;

  always_ff @(posedge Z1 or negedge CLR) begin
    if (!CLR) begin
      state_q    <= HUNT;
      hist_q     <= '0;
      bitn_q     <= '0;
      miss_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      bitn_q     <= bitn_d;
      miss_q     <= miss_d;
      sync_err_q <= sync_err_d;
    end
  end

  // drop is combinational so the top can suppress the n=39 capture on the same edge
  always_comb begin
    hist_d     = {hist_q[SIG_BITS-2:0], Z2};
    state_d    = state_q;
    bitn_d     = bitn_q;
    miss_d     = miss_q;
    sync_err_d = 1'b0;
    drop       = 1'b0;
    case (state_q)
      HUNT: begin
        if (hist_d == SYNC_SIG) begin
          state_d = LOCKED;
          bitn_d  = '0;
          miss_d  = '0;
        end
      end
      LOCKED: begin
        bitn_d = (bitn_q == LAST_BIT) ? '0 : bitn_q + 6'd1;
        if (Z2 == z2_expect(bitn_q)) begin
          miss_d = '0;
        end else if (miss_q == MISS_LAST) begin
          drop       = 1'b1;
          state_d    = HUNT;
          bitn_d     = '0;
          miss_d     = '0;
          sync_err_d = 1'b1;
        end else begin
          miss_d = miss_q + 2'd1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign lock     = (state_q == LOCKED);
  assign bitn     = bitn_q;
  assign sync_err = sync_err_q;

endmodule

// File: rtl/z_track_decoder.sv
// Drum Z2/Z3 receiver: rebuilds the sector address per word and flags sequence, framing and sync faults.
// Latency: ADR/ADR_VALID one Z1 edge after address bit 6 (n=38); no backpressure (free-running track).
module z_track_decoder
  import z_track_decoder_pkg::*;
(
  input  logic                Z1,
  input  logic                CLR,
  input  logic                Z2,
  input  logic                Z3,
  output logic [ADR_BITS-1:0] ADR,
  output logic                ADR_VALID,
  output logic                LOCK,
  output logic [BITN_W-1:0]   BITN,
  output logic                SEQ_ERR,
  output logic                FRAME_ERR,
  output logic                SYNC_ERR
);

  logic                drop;
  logic                in_adr;
  logic                adr_end;
  logic                have_prev;
  logic [ADR_BITS-1:0] shreg;

  z2_sync_detector u_sync (
    .Z1       (Z1),
    .CLR      (CLR),
    .Z2       (Z2),
    .lock     (LOCK),
    .bitn     (BITN),
    .sync_err (SYNC_ERR),
    .drop     (drop)
  );

  assign in_adr  = LOCK && (BITN >= ADR_FIRST) && (BITN <= ADR_LAST);
  assign adr_end = LOCK && (BITN == LAST_BIT) && !drop;

  always_ff @(posedge Z1 or negedge CLR) begin
    if (!CLR) begin
      shreg     <= '0;
      ADR       <= '0;
      ADR_VALID <= 1'b0;
      SEQ_ERR   <= 1'b0;
      FRAME_ERR <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      ADR_VALID <= 1'b0;
      SEQ_ERR   <= 1'b0;
      FRAME_ERR <= LOCK && Z3 && !in_adr;
      // LSB arrives first, so it ends up in bit 0 after seven shifts
      if (in_adr)
        shreg <= {Z3, shreg[ADR_BITS-1:1]};
      if (drop) begin
        have_prev <= 1'b0;
      end else if (adr_end) begin
        ADR       <= shreg;
        ADR_VALID <= 1'b1;
        SEQ_ERR   <= have_prev && (shreg != ADR + 7'd1);
        have_prev <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_z_track_decoder.sv
// Scoreboard bench for z_track_decoder: streams generated drum words and checks addresses and fault pulses.
module tb_z_track_decoder;

  logic       Z1 = 1'b0;
  logic       CLR;
  logic       Z2;
  logic       Z3;
  logic [6:0] ADR;
  logic       ADR_VALID;
  logic       LOCK;
  logic [5:0] BITN;
  logic       SEQ_ERR;
  logic       FRAME_ERR;
  logic       SYNC_ERR;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] sb[$];
  int   rise_n, sync_n, sync_cnt, frame_n, frame_cnt;
  logic prev_lock;

  localparam logic [39:0] NONE = 40'd0;

  always #5 Z1 = ~Z1;

  z_track_decoder dut (
    .Z1        (Z1),
    .CLR       (CLR),
    .Z2        (Z2),
    .Z3        (Z3),
    .ADR       (ADR),
    .ADR_VALID (ADR_VALID),
    .LOCK      (LOCK),
    .BITN      (BITN),
    .SEQ_ERR   (SEQ_ERR),
    .FRAME_ERR (FRAME_ERR),
    .SYNC_ERR  (SYNC_ERR)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic z2_pat(input int n);
    return (n == 31) || (n == 32) || (n == 33) || (n == 38) || (n == 39);
  endfunction

  task automatic send_word(input logic [6:0] adr, input bit vld, input bit seq,
                           input logic [39:0] kill, input logic [39:0] z3_set,
                           input int clr_n);
    logic [7:0] e;
    logic       abit;
    rise_n = -1; sync_n = -1; sync_cnt = 0; frame_n = -1; frame_cnt = 0;
    if (vld) sb.push_back({seq, adr});
    for (int n = 0; n < 40; n++) begin
      @(negedge Z1);
      if (clr_n >= 0 && n == clr_n + 3) CLR = 1'b1;
      abit = 1'b0;
      if (n >= 32 && n <= 38) abit = adr[n-32];
      Z2 = z2_pat(n) & ~kill[n];
      Z3 = abit | z3_set[n];
      @(posedge Z1);
      #1;
      if (LOCK && !prev_lock) rise_n = n;
      prev_lock = LOCK;
      if (SYNC_ERR) begin sync_n = n; sync_cnt++; end
      if (FRAME_ERR) begin frame_n = n; frame_cnt++; end
      if (n == 20) chk("bitn", int'(BITN), LOCK ? 21 : 0);
      if (ADR_VALID) begin
        if (sb.size() == 0) begin
          chk("vld_unexpected", int'(ADR_VALID), 0);
        end else begin
          e = sb.pop_front();
          chk("adr", int'(ADR), int'(e[6:0]));
          chk("seq_err", int'(SEQ_ERR), int'(e[7]));
          chk("vld_bit", n, 39);
        end
      end else begin
        chk("seq_err_stray", int'(SEQ_ERR), 0);
      end
      if (n == clr_n) begin
        #1 CLR = 1'b0;
        #1 chk("clr_outputs",
               int'({ADR, ADR_VALID, LOCK, BITN, SEQ_ERR, FRAME_ERR, SYNC_ERR}), 0);
        prev_lock = LOCK;
      end
    end
  endtask

  task automatic word(input logic [6:0] adr, input bit vld, input bit seq,
                      input logic [39:0] kill, input logic [39:0] z3_set, input int clr_n,
                      input bit exp_lock, input int exp_rise, input int exp_sync,
                      input int exp_frame);
    send_word(adr, vld, seq, kill, z3_set, clr_n);
    chk("lock_end",   int'(LOCK), int'(exp_lock));
    chk("lock_rise",  rise_n, exp_rise);
    chk("sync_bit",   sync_n, exp_sync);
    chk("sync_cnt",   sync_cnt, (exp_sync >= 0) ? 1 : 0);
    chk("frame_bit",  frame_n, exp_frame);
    chk("frame_cnt",  frame_cnt, (exp_frame >= 0) ? 1 : 0);
    chk("sb_pending", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    logic [39:0] k31_32;
    logic [39:0] z3_10;
    logic [39:0] z3_39;
    k31_32 = NONE; k31_32[31] = 1'b1; k31_32[32] = 1'b1;
    z3_10  = NONE; z3_10[10]  = 1'b1;
    z3_39  = NONE; z3_39[39]  = 1'b1;

    CLR = 1'b0; Z2 = 1'b0; Z3 = 1'b0; prev_lock = 1'b0;
    repeat (3) @(posedge Z1);
    #1;
    chk("rst_adr",   int'(ADR), 0);
    chk("rst_vld",   int'(ADR_VALID), 0);
    chk("rst_lock",  int'(LOCK), 0);
    chk("rst_bitn",  int'(BITN), 0);
    chk("rst_seq",   int'(SEQ_ERR), 0);
    chk("rst_frame", int'(FRAME_ERR), 0);
    chk("rst_sync",  int'(SYNC_ERR), 0);
    CLR = 1'b1;

    // acquisition and in-order stream
    word(7'd1,   0, 0, NONE, NONE, -1, 1, 39, -1, -1);
    word(7'd2,   1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    word(7'd3,   1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    word(7'd4,   1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    // jump, then legal wrap 127 -> 0
    word(7'd126, 1, 1, NONE, NONE, -1, 1, -1, -1, -1);
    word(7'd127, 1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    word(7'd0,   1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    word(7'd1,   1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    // sequence gaps
    word(7'd5,   1, 1, NONE, NONE, -1, 1, -1, -1, -1);
    word(7'd6,   1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    word(7'd9,   1, 1, NONE, NONE, -1, 1, -1, -1, -1);
    word(7'd10,  1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    // two Z2 misses drop lock, reacquire, first address after is not flagged
    word(7'd11,  0, 0, k31_32, NONE, -1, 0, -1, 32, -1);
    word(7'd12,  0, 0, NONE, NONE, -1, 1, 39, -1, -1);
    word(7'd13,  1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    word(7'd14,  1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    // stray Z3 bits outside the address field
    word(7'd15,  1, 0, NONE, z3_10, -1, 1, -1, -1, 10);
    word(7'd16,  1, 0, NONE, z3_39, -1, 1, -1, -1, 39);
    // mid-word clear at n=35, released three bit-times later
    word(7'd17,  0, 0, NONE, NONE, 35, 0, -1, -1, -1);
    word(7'd18,  0, 0, NONE, NONE, -1, 1, 39, -1, -1);
    word(7'd19,  1, 0, NONE, NONE, -1, 1, -1, -1, -1);
    word(7'd20,  1, 0, NONE, NONE, -1, 1, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
